pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage core. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- multi-cycle data-memory waits, with a timeout;
- branch redirects;
- load-use hazards.

It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: memory-wait FSM with timeout,
// branch redirect flushes, load-use stalls and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_werf,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             dmem_err,
    output logic             in_mem_wait,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_wait_cnt;
    logic [7:0]         w_wait_cnt_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_mstall;
    logic               w_load_use;

    assign w_load_use = ex_is_load & ex_werf & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mstall       = 1'b0;
        dmem_err       = 1'b0;
        dmem_req       = 1'b0;
        case (r_state)
            RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ready) begin
                    w_mstall       = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == TIMEOUT) begin
                    dmem_err       = 1'b1;
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_mstall       = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // A branch seen during mstall is held in EX (EX/MEM frozen) and acted on later.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (w_mstall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_mem_wait = (r_state == MEM_WAIT);
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4): expected control
// vectors are queued per driven cycle and compared against sampled DUT outputs.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_werf, ex_is_load, ex_branch_taken;
    logic       mem_access, dmem_ready;
    logic       dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, dmem_err, in_mem_wait;
    logic [3:0] stall_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_werf(ex_werf), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .dmem_err(dmem_err),
        .in_mem_wait(in_mem_wait), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //  if_id_flush, id_ex_flush, mem_wb_flush, dmem_err, in_mem_wait}
    localparam logic [10:0] V_NORM   = 11'b0_11111_000_00;
    localparam logic [10:0] V_HIT    = 11'b1_11111_000_00;
    localparam logic [10:0] V_MS_RUN = 11'b1_00001_001_00;
    localparam logic [10:0] V_MS_MW  = 11'b1_00001_001_01;
    localparam logic [10:0] V_RDY_MW = 11'b1_11111_000_01;
    localparam logic [10:0] V_RDY_BR = 11'b1_11111_110_01;
    localparam logic [10:0] V_TMO    = 11'b1_11111_000_11;
    localparam logic [10:0] V_LU     = 11'b0_00111_010_00;
    localparam logic [10:0] V_BR     = 11'b0_11111_110_00;

    typedef struct packed {
        logic [10:0] ctl;
        logic [3:0]  cnt;
    } rec_t;

    rec_t  exp_q[$];
    rec_t  obs_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic [3:0] exp_cnt = 4'd0;

    wire [10:0] w_obs = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush, mem_wb_flush, dmem_err, in_mem_wait};

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_werf = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_werf = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    endtask

    // Inputs already applied; queue expectation, sample mid-cycle, advance to next cycle.
    task automatic drive_cycle(input logic [10:0] ectl, input string tag);
        exp_q.push_back('{ctl: ectl, cnt: exp_cnt});
        tag_q.push_back(tag);
        @(negedge clk);
        obs_q.push_back('{ctl: w_obs, cnt: stall_cnt});
        if (!ectl[9] && !rst && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rec_t e, o; string t;
        rst = 1'b1;
        idle();
        #2;
        drive_cycle(V_NORM, "reset_idle");
        mem_access = 1'b1;
        drive_cycle(V_MS_RUN, "reset_run_eqs");
        idle();
        rst = 1'b0;
        drive_cycle(V_NORM, "after_reset");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_load_use();
        rec_t e, o; string t;
        idle(); set_load_use();
        drive_cycle(V_LU, "lu_stall");
        idle(); id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        drive_cycle(V_NORM, "lu_clear");
        set_load_use(); id_use_rs1 = 1'b0; id_rs2 = 5'd5;
        drive_cycle(V_LU, "lu_rs2");
        idle();
        drive_cycle(V_NORM, "lu_rs2_clear");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_lu_suppress();
        rec_t e, o; string t;
        idle(); set_load_use(); ex_rd = 5'd0; id_rs1 = 5'd0;
        drive_cycle(V_NORM, "lu_rd0");
        idle(); set_load_use(); id_use_rs1 = 1'b0;
        drive_cycle(V_NORM, "lu_no_use");
        idle(); set_load_use(); ex_werf = 1'b0;
        drive_cycle(V_NORM, "lu_no_werf");
        idle(); dmem_ready = 1'b1;
        drive_cycle(V_NORM, "ready_no_access");
        idle(); mem_access = 1'b1; dmem_ready = 1'b1;
        drive_cycle(V_HIT, "mem_hit");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_mem_wait();
        rec_t e, o; string t;
        idle(); mem_access = 1'b1;
        drive_cycle(V_MS_RUN, "mw_c0");
        drive_cycle(V_MS_MW,  "mw_c1");
        drive_cycle(V_MS_MW,  "mw_c2");
        dmem_ready = 1'b1;
        drive_cycle(V_RDY_MW, "mw_ready");
        idle();
        drive_cycle(V_NORM, "mw_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_timeout();
        rec_t e, o; string t;
        idle(); mem_access = 1'b1;
        drive_cycle(V_MS_RUN, "to_c0");
        for (int i = 1; i < 4; i++) drive_cycle(V_MS_MW, $sformatf("to_c%0d", i));
        drive_cycle(V_TMO, "to_err");
        idle();
        drive_cycle(V_NORM, "to_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_simultaneous();
        rec_t e, o; string t;
        idle(); set_load_use(); ex_branch_taken = 1'b1;
        drive_cycle(V_BR, "br_and_lu");
        idle(); mem_access = 1'b1; ex_branch_taken = 1'b1;
        drive_cycle(V_MS_RUN, "br_mw_c0");
        drive_cycle(V_MS_MW,  "br_mw_c1");
        dmem_ready = 1'b1;
        drive_cycle(V_RDY_BR, "br_mw_ready");
        idle();
        drive_cycle(V_NORM, "br_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_wait();
        rec_t e, o; string t;
        idle(); mem_access = 1'b1;
        drive_cycle(V_MS_RUN, "rmw_c0");
        drive_cycle(V_MS_MW,  "rmw_c1");
        vectors++;
        if (in_mem_wait !== 1'b1) begin miscompares++; $display("FAIL rmw_pre in_mem_wait got %b want 1", in_mem_wait); end
        rst = 1'b1;
        #1;
        vectors++;
        if (in_mem_wait !== 1'b0) begin miscompares++; $display("FAIL rmw_async in_mem_wait got %b want 0", in_mem_wait); end
        vectors++;
        if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL rmw_async stall_cnt got %0d want 0", stall_cnt); end
        vectors++;
        if (dmem_err !== 1'b0) begin miscompares++; $display("FAIL rmw_async dmem_err got %b want 0", dmem_err); end
        exp_cnt = 4'd0;
        mem_access = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        drive_cycle(V_NORM, "rmw_after");
        set_load_use();
        for (int i = 0; i < 20; i++) drive_cycle(V_LU, $sformatf("sat_%0d", i));
        idle();
        drive_cycle(V_NORM, "sat_final");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            vectors++;
            if (o.ctl !== e.ctl) begin miscompares++; $display("FAIL %s ctl got %b want %b", t, o.ctl, e.ctl); end
            vectors++;
            if (o.cnt !== e.cnt) begin miscompares++; $display("FAIL %s stall_cnt got %0d want %0d", t, o.cnt, e.cnt); end
        end
        vectors++;
        if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_value stall_cnt got %0d want 15", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_suppress();
        test_mem_wait();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
